// File: rtl/alu_pkg.sv
// Shared funct codes and FSM state type for the multicycle ALU slice.
package alu_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'd16;
   localparam logic [5:0] FUNCT_MFLO  = 6'd18;
   localparam logic [5:0] FUNCT_MULTU = 6'd25;
   localparam logic [5:0] FUNCT_DIVU  = 6'd27;
   localparam logic [5:0] FUNCT_ADD   = 6'd32;
   localparam logic [5:0] FUNCT_SUB   = 6'd34;
   localparam logic [5:0] FUNCT_AND   = 6'd36;
   localparam logic [5:0] FUNCT_OR    = 6'd37;
   localparam logic [5:0] FUNCT_SLT   = 6'd42;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } aluState;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the execute-stage controller and the ALU.
interface multicycle_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dataOut;
   logic             overflow;
   logic             zero;

   modport master (
      output start, Signal, dataA, dataB,
      input  busy, done, dataOut, overflow, zero
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output busy, done, dataOut, overflow, zero
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider sharing one work register.
// Divider logic exists only when MULTICYCLE_ALU_DIV_EN is defined.
module alu_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
`ifdef MULTICYCLE_ALU_DIV_EN
   input  logic             divMode,
`endif
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             step,
   output logic             lastStep,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] nextLo
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] work;
   logic [2*WIDTH-1:0] workNext;
   logic [WIDTH-1:0]   operand;
   logic [CW-1:0]      count;
   logic [WIDTH:0]     mulSum;
`ifdef MULTICYCLE_ALU_DIV_EN
   logic               isDiv;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   diff;
`endif

   // Upper half is the partial product (or remainder), lower half the multiplier (or quotient).
   always_comb begin
      mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{work[0]}} & operand};
      workNext = {mulSum, work[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
      shifted = work[2*WIDTH-1:WIDTH-1];
      diff    = shifted[WIDTH-1:0] - operand;
      if (isDiv) begin
         if (shifted >= {1'b0, operand}) begin
            workNext = {diff, work[WIDTH-2:0], 1'b1};
         end else begin
            workNext = {shifted[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   assign lastStep = (count == '0);
   assign nextLo   = workNext[WIDTH-1:0];

   // HI/LO are written only on the final iteration so an aborted run never leaks partial values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         work    <= '0;
         operand <= '0;
         count   <= '0;
         hi      <= '0;
         lo      <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
         isDiv   <= 1'b0;
`endif
      end else if (load) begin
         work    <= {{WIDTH{1'b0}}, opA};
         operand <= opB;
         count   <= CW'(WIDTH - 1);
`ifdef MULTICYCLE_ALU_DIV_EN
         isDiv   <= divMode;
`endif
      end else if (step) begin
         work  <= workNext;
         count <= count - CW'(1);
         if (count == '0) begin
            hi <= workNext[2*WIDTH-1:WIDTH];
            lo <= workNext[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle logic/arith plus iterative MULTU/DIVU into HI/LO.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; otherwise DIVU acts as an unknown funct.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   multicycle_alu_if.slave bus
);
   aluState          state;
   logic             busyReg;
   logic             doneReg;
   logic             overflowReg;
   logic             zeroReg;
   logic [WIDTH-1:0] dataOutReg;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] aluResult;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] nextLo;
   logic             aluOverflow;
   logic             isMul;
   logic             isDiv;
   logic             lastStep;
   logic             loadUnit;
   logic             stepUnit;

   assign isMul = (bus.Signal == FUNCT_MULTU);
`ifdef MULTICYCLE_ALU_DIV_EN
   assign isDiv = (bus.Signal == FUNCT_DIVU);
`else
   assign isDiv = 1'b0;
`endif

   assign sum      = bus.dataA + bus.dataB;
   assign diff     = bus.dataA - bus.dataB;
   assign loadUnit = (state == IDLE) && bus.start && (isMul || isDiv);
   assign stepUnit = (state == MUL) || (state == DIV);

   // SLT uses a true signed compare so it stays correct when A-B overflows.
   always_comb begin
      aluResult   = '0;
      aluOverflow = 1'b0;
      case (bus.Signal)
         FUNCT_ADD: begin
            aluResult   = sum;
            aluOverflow = (bus.dataA[WIDTH-1] == bus.dataB[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.dataA[WIDTH-1]);
         end
         FUNCT_SUB: begin
            aluResult   = diff;
            aluOverflow = (bus.dataA[WIDTH-1] != bus.dataB[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.dataA[WIDTH-1]);
         end
         FUNCT_AND:  aluResult = bus.dataA & bus.dataB;
         FUNCT_OR:   aluResult = bus.dataA | bus.dataB;
         FUNCT_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
         FUNCT_MFHI: aluResult = hi;
         FUNCT_MFLO: aluResult = lo;
         default:    aluResult = '0;
      endcase
   end

   alu_muldiv_unit #(
      .WIDTH(WIDTH)
   ) muldiv (
      .clk     (clk),
      .reset   (reset),
      .load    (loadUnit),
`ifdef MULTICYCLE_ALU_DIV_EN
      .divMode (isDiv),
`endif
      .opA     (bus.dataA),
      .opB     (bus.dataB),
      .step    (stepUnit),
      .lastStep(lastStep),
      .hi      (hi),
      .lo      (lo),
      .nextLo  (nextLo)
   );

   // Starts are only looked at in IDLE, so requests while busy are dropped rather than queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         busyReg     <= 1'b0;
         doneReg     <= 1'b0;
         dataOutReg  <= '0;
         overflowReg <= 1'b0;
         zeroReg     <= 1'b1;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (isMul) begin
                     state   <= MUL;
                     busyReg <= 1'b1;
                  end else if (isDiv) begin
                     state   <= DIV;
                     busyReg <= 1'b1;
                  end else begin
                     doneReg     <= 1'b1;
                     dataOutReg  <= aluResult;
                     overflowReg <= aluOverflow;
                     zeroReg     <= (aluResult == '0);
                  end
               end
            end
            MUL, DIV: begin
               if (lastStep) begin
                  state       <= IDLE;
                  busyReg     <= 1'b0;
                  doneReg     <= 1'b1;
                  dataOutReg  <= nextLo;
                  overflowReg <= 1'b0;
                  zeroReg     <= (nextLo == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busyReg;
   assign bus.done     = doneReg;
   assign bus.dataOut  = dataOutReg;
   assign bus.overflow = overflowReg;
   assign bus.zero     = zeroReg;

endmodule
